// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised full-duplex SPI master, one word per request.
//   Word width, SCLK half-period divider, CPOL/CPHA per transfer, NUM_SS selects.
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   start_i                request; accepted when start_i & ready_o
//   tx_data_i, ss_sel_i,   word, slave index, clock polarity and phase,
//   cpol_i, cpha_i         all latched at acceptance
//   ready_o                high only while idle
//   rx_data_o, rx_valid_o  received word (held) and its one-cycle strobe
//   spi_clk_o, spi_mosi_o, spi_miso_i, spi_ss_o   SPI bus (selects active low)
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds loopback_i; when latched
//   high the RX path samples the internal MOSI bit and SCLK/SS stay quiet.
module spi_master_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 1
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic                                         start_i,
  input  logic [DATA_W-1:0]                            tx_data_i,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel_i,
  input  logic                                         cpol_i,
  input  logic                                         cpha_i,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                                         loopback_i,
`endif
  output logic                                         ready_o,
  output logic [DATA_W-1:0]                            rx_data_o,
  output logic                                         rx_valid_o,
  output logic                                         spi_clk_o,
  output logic                                         spi_mosi_o,
  input  logic                                         spi_miso_i,
  output logic [NUM_SS-1:0]                            spi_ss_o
);

  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam int EW   = $clog2(2 * DATA_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     div_q;
  logic [EW-1:0]     edge_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [NUM_SS-1:0] ss_q;
  logic              cpol_q, cpha_q, sclk_q, mosi_q, rx_valid_q, lb_q;
  logic              lb_in, div_tc, last_edge, leading, toggle;
  logic              sample_en, shift_en, miso_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_in = loopback_i;
`else
  assign lb_in = 1'b0;
`endif

  assign div_tc    = (div_q == '0);
  assign last_edge = (edge_q == EW'(2 * DATA_W - 1));
  // edge_q counts toggles already made, so an even count means the next one leads
  assign leading   = ~edge_q[0];
  assign toggle    = (state_q == ST_XFER) && div_tc;
  assign sample_en = toggle && (leading ^ cpha_q);
  assign shift_en  = toggle && (cpha_q ? leading : (!leading && !last_edge));
  assign miso_bit  = lb_q ? mosi_q : spi_miso_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SETUP;
      ST_SETUP: if (div_tc) state_d = ST_XFER;
      ST_XFER:  if (div_tc && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (div_tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      ss_q       <= '1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      lb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        sclk_q <= cpol_i;
        mosi_q <= 1'b0;
        if (start_i) begin
          tx_sh_q <= tx_data_i;
          rx_sh_q <= '0;
          cpol_q  <= cpol_i;
          cpha_q  <= cpha_i;
          lb_q    <= lb_in;
          div_q   <= DW'(CLK_DIV - 1);
          edge_q  <= '0;
          // CPHA=0 slaves sample the first leading edge, so the MSB must already be out
          mosi_q  <= cpha_i ? 1'b0 : tx_data_i[DATA_W-1];
          for (int i = 0; i < NUM_SS; i++)
            ss_q[i] <= !((ss_sel_i == SS_W'(i)) && !lb_in);
        end
      end else begin
        div_q <= div_tc ? DW'(CLK_DIV - 1) : div_q - 1'b1;
      end
      if (toggle) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + 1'b1;
      end
      if (shift_en) begin
        mosi_q  <= cpha_q ? tx_sh_q[DATA_W-1] : tx_sh_q[DATA_W-2];
        tx_sh_q <= tx_sh_q << 1;
      end
      if (sample_en)
        rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_bit};
      if ((state_q == ST_HOLD) && div_tc) begin
        ss_q       <= '1;
        rx_data_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
        mosi_q     <= 1'b0;
        lb_q       <= 1'b0;
      end
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_clk_o  = lb_q ? cpol_q : sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_ss_o   = ss_q;

endmodule

// File: tb/tb_spi_master_gen.sv
module tb_spi_master_gen;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic [1:0] ss_sel_i = '0;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       lb_drv = 1'b0;
  logic       ready_o, rx_valid_o, spi_clk_o, spi_mosi_o, spi_miso_i;
  logic [7:0] rx_data_o;
  logic [3:0] spi_ss_o;

  spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .tx_data_i(tx_data_i),
    .ss_sel_i(ss_sel_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_i(lb_drv),
`endif
    .ready_o(ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
    .spi_ss_o(spi_ss_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave model: shifts off SCLK edges only, as a real peripheral would
  logic [7:0] slave_word = 8'h00;
  logic       cur_cpha = 1'b0;
  logic [7:0] slv_tx = '0, slv_rx = '0;
  int         slv_edges = 0;
  logic       slv_act;
  assign slv_act    = ~&spi_ss_o;
  assign spi_miso_i = slv_act ? slv_tx[7] : 1'b0;

  always @(posedge slv_act) begin
    slv_tx    = slave_word;
    slv_rx    = '0;
    slv_edges = 0;
  end

  always @(spi_clk_o) begin
    if (slv_act && rstn_i) begin
      slv_edges++;
      if (((slv_edges % 2) == 1) ^ cur_cpha)
        slv_rx = {slv_rx[6:0], spi_mosi_o};
      else if (!(cur_cpha && slv_edges == 1))
        slv_tx = slv_tx << 1;
    end
  end

  // scoreboard
  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         acc;
    logic [3:0] ss;
    logic       lb;
    logic       cpol;
  } exp_t;
  exp_t sb[$];

  int   cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [3:0] ss_seen = 4'hF;
  int   tog_cnt = 0;
  logic prev_sclk = 1'b0;
  int   n_acc = 0, n_valid = 0, last_acc = 0;
  logic b2b_mode = 1'b0;

  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      n_valid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", rx_data_o, e.rx);
        chk("latency", cyc - e.acc, 36);
        chk("ss_during", ss_seen, e.ss);
        chk("ss_after", spi_ss_o, 4'hF);
        chk("sclk_idle_after", spi_clk_o, e.cpol);
        chk("sclk_toggles", tog_cnt, e.lb ? 0 : 16);
        chk("ready_at_valid", ready_o, 1);
        if (!e.lb) chk("mosi_word", slv_rx, e.tx);
      end
    end
    if (start_i && ready_o && rstn_i) begin
      exp_t e;
      e.tx   = tx_data_i;
      e.lb   = lb_drv;
      e.rx   = lb_drv ? tx_data_i : slave_word;
      e.acc  = cyc + 1;
      e.ss   = lb_drv ? 4'hF : ~(4'b0001 << ss_sel_i);
      e.cpol = cpol_i;
      sb.push_back(e);
      if (b2b_mode && n_acc > 0) chk("b2b_gap", e.acc - last_acc, 37);
      last_acc = e.acc;
      n_acc++;
      ss_seen = 4'hF;
      tog_cnt = 0;
    end else begin
      if (spi_ss_o != 4'hF) ss_seen = spi_ss_o;
      if (!ready_o && spi_clk_o != prev_sclk) tog_cnt++;
    end
    prev_sclk = spi_clk_o;
  end

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk_i);
      k++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                      input logic pha, input logic lb);
    @(posedge clk_i); #1;
    cpol_i = pol; cpha_i = pha; cur_cpha = pha;
    repeat (2) @(posedge clk_i);
    #1;
    chk("sclk_idle_before", spi_clk_o, pol);
    chk("ready_idle", ready_o, 1);
    tx_data_i = tx; ss_sel_i = sel; lb_drv = lb; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; lb_drv = 1'b0;
    drain();
  endtask

  initial begin
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_rxdata", rx_data_o, 8'h00);
    chk("rst_sclk", spi_clk_o, 0);
    chk("rst_mosi", spi_mosi_o, 0);
    chk("rst_ss", spi_ss_o, 4'hF);
    repeat (3) @(posedge clk_i);
    #3 rstn_i = 1'b1;

    slave_word = 8'h3C;
    xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
    slave_word = 8'h7E;
    xfer(8'h81, 2'd1, 1'b0, 1'b1, 1'b0);
    xfer(8'h81, 2'd1, 1'b1, 1'b0, 1'b0);
    xfer(8'h81, 2'd1, 1'b1, 1'b1, 1'b0);
    slave_word = 8'hC3;
    xfer(8'h5B, 2'd2, 1'b0, 1'b0, 1'b0);
    xfer(8'h24, 2'd3, 1'b0, 1'b0, 1'b0);

    // back-to-back with start held high
    @(posedge clk_i); #1;
    cpol_i = 1'b0; cpha_i = 1'b1; cur_cpha = 1'b1;
    slave_word = 8'h96; tx_data_i = 8'h69; ss_sel_i = 2'd1;
    @(posedge clk_i); #1;
    n_acc = 0; n_valid = 0; b2b_mode = 1'b1;
    start_i = 1'b1;
    repeat (3 * 37 - 5) @(posedge clk_i);
    #1 start_i = 1'b0;
    drain();
    b2b_mode = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_valids", n_valid, 3);

    // reset during XFER at the fifth SCLK edge
    @(posedge clk_i); #1;
    cpol_i = 1'b0; cpha_i = 1'b0; cur_cpha = 1'b0;
    slave_word = 8'h11; tx_data_i = 8'hEE; ss_sel_i = 2'd0;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    begin
      int k = 0;
      while (tog_cnt < 5 && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      chk("edge5_timeout", (tog_cnt >= 5), 1);
    end
    #1 rstn_i = 1'b0;
    sb.delete();
    #1;
    chk("abort_ss", spi_ss_o, 4'hF);
    chk("abort_sclk", spi_clk_o, 0);
    chk("abort_valid", rx_valid_o, 0);
    chk("abort_mosi", spi_mosi_o, 0);
    repeat (2) @(posedge clk_i);
    #3 rstn_i = 1'b1;
    n_valid = 0;
    repeat (40) @(posedge clk_i);
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_no_valid", n_valid, 0);

    slave_word = 8'hA7;
    xfer(8'h3D, 2'd2, 1'b0, 1'b0, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
    slave_word = 8'h00;
    xfer(8'h5A, 2'd1, 1'b0, 1'b0, 1'b1);
    xfer(8'h5A, 2'd3, 1'b1, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
